gate_logic_pipe: RTL

Parametrised, pipelined bitwise logic unit: the next generation of the single-function N-bit gate blocks. Applies one of eight bitwise operations to two N-bit operands, selected per transaction. Carries results through a configurable-depth register pipeline with a valid/ready handshake on both sides. Sits between operand producers and any consumer that can stall, so back-pressure propagates without dropping or duplicating data.

---
 rtl/gate_pkg.sv | 49 ++++
 rtl/gate_pipe_stage.sv | 55 +++++
 rtl/gate_logic_pipe.sv | 100 ++++++++++
 3 files changed

// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Shared types and the bitwise evaluation function for the
//               gate_logic_pipe block.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

  // Deepest pipeline the block is meant to be built with.
  localparam int MAX_STAGES = 4;

  // Operand width the evaluation function works at; callers size-cast in and out.
  // Any instance must keep N <= MAX_N.
  localparam int MAX_N = 64;

  typedef enum logic [2:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_XNOR  = 3'd3,
    OP_NAND  = 3'd4,
    OP_NOR   = 3'd5,
    OP_NOTA  = 3'd6,
    OP_PASSA = 3'd7
  } op_t;

  // Purely bitwise: every result bit depends only on the same bit of a and b.
  // Callers truncate the result to their own width.
  function automatic logic [MAX_N-1:0] gate_eval(input op_t op,
                                                 input logic [MAX_N-1:0] a,
                                                 input logic [MAX_N-1:0] b);
    logic [MAX_N-1:0] r;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_XNOR:  r = ~(a ^ b);
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_NOTA:  r = ~a;
      OP_PASSA: r = a;
      default:  r = a;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : gate_pipe_stage
// Description : One valid/ready register slice. Loads when empty or when its
//               contents leave this cycle; otherwise holds data and valid.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_pipe_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             w_ready;

  assign w_ready = !valid_q || out_ready;

  // Next state: take new contents when there is room, else hold everything.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (w_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Slice registers; reset empties the slice and clears its data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/gate_logic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gate_logic_pipe
// Description : Eight-function bitwise logic unit behind a STAGES-deep
//               valid/ready register pipeline with combinational back-pressure.
//               Define GATE_PIPE_REDUCE_EN to add the Z (all-zero) and
//               P (even parity) result flags.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_logic_pipe
  import gate_pkg::*;
#(
  parameter int N      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  op_t          Op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] F
`ifdef GATE_PIPE_REDUCE_EN
  ,
  output logic         Z,
  output logic         P
`endif
);

`ifdef GATE_PIPE_REDUCE_EN
  // Flags ride in the two bits above the result: {Z, P, F}.
  localparam int DW = N + 2;
`else
  localparam int DW = N;
`endif

  logic [N-1:0]    w_result;
  logic [DW-1:0]   w_in_data;
  logic [STAGES-1:0] w_valid;
  logic [DW-1:0]   w_data [STAGES];
  logic [STAGES:0] w_ready;

  // Operation decode and optional flag generation, ahead of stage 0.
  always_comb begin
    w_result = N'(gate_eval(Op, MAX_N'(A), MAX_N'(B)));
`ifdef GATE_PIPE_REDUCE_EN
    w_in_data = {~|w_result, ~^w_result, w_result};
`else
    w_in_data = w_result;
`endif
  end

  // Ready chain from the consumer back to the input; built from slice valids
  // so the path is a plain combinational cascade with no skid storage.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_ready[k] = !w_valid[k] || w_ready[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          w_stage_in_valid;
    logic [DW-1:0] w_stage_in_data;

    if (k == 0) begin : g_first
      assign w_stage_in_valid = in_valid;
      assign w_stage_in_data  = w_in_data;
    end else begin : g_next
      assign w_stage_in_valid = w_valid[k-1];
      assign w_stage_in_data  = w_data[k-1];
    end

    gate_pipe_stage #(
      .WIDTH(DW)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (w_stage_in_valid),
      .in_data  (w_stage_in_data),
      .out_ready(w_ready[k+1]),
      .out_valid(w_valid[k]),
      .out_data (w_data[k])
    );
  end

  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[STAGES-1];
  assign F         = w_data[STAGES-1][N-1:0];
`ifdef GATE_PIPE_REDUCE_EN
  assign Z         = w_data[STAGES-1][N+1];
  assign P         = w_data[STAGES-1][N];
`endif

endmodule
`default_nettype wire
